// File: rtl/serial_subtractor_pkg.sv
// Shared types and parameter checks for the serial ripple-borrow subtractor.
// Holds the FSM state encoding and the legal-SLICE rule used at elaboration.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // SLICE must be 1, 2, 4 or the full width, and must divide the width evenly.
    function automatic bit slice_legal(input int width, input int slice);
        bit ok;
        if (slice <= 0 || width <= 0) begin
            ok = 1'b0;
        end else if ((width % slice) != 0) begin
            ok = 1'b0;
        end else begin
            ok = (slice == 1) || (slice == 2) || (slice == 4) || (slice == width);
        end
        return ok;
    endfunction

    function automatic int run_cycles(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational SLICE-bit ripple-borrow stage, reused by the top every RUN cycle.
// Produces the slice difference bits and the borrow out of each bit.
module sub_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] d_o,
    output logic [SLICE:1]   borrow_o
);

    // Returns {borrow[SLICE:1], d[SLICE-1:0]}; ripple kept in a local variable.
    function automatic logic [2*SLICE-1:0] ripple(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             bin
    );
        logic [SLICE-1:0] d;
        logic [SLICE-1:0] bo;
        logic             br;
        br = bin;
        for (int i = 0; i < SLICE; i++) begin
            d[i]  = a[i] ^ b[i] ^ br;
            bo[i] = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br);
            br    = bo[i];
        end
        return {bo, d};
    endfunction

    // Slice evaluation
    always_comb begin
        {borrow_o, d_o} = ripple(a_i, b_i, bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor behind a valid/ready handshake.
// Computes a - b - bin one SLICE per RUN cycle, exposing the full borrow chain.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               bin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   diff,
    output logic [WIDTH:0]     borrow,
    output logic [2*WIDTH:0]   res
);

    localparam int NSLICE = run_cycles(WIDTH, SLICE);
    localparam int IDX_W  = $clog2(NSLICE + 1);
    localparam int BASE_W = $clog2(WIDTH + 1);

    if (!slice_legal(WIDTH, SLICE)) begin : g_bad_slice
        $error("serial_subtractor: SLICE must be 1, 2, 4 or WIDTH and divide WIDTH");
    end

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic [WIDTH:0]     borrow_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [BASE_W-1:0]  base_s;
    logic               last_s;
    logic [SLICE-1:0]   sl_a_s;
    logic [SLICE-1:0]   sl_b_s;
    logic               sl_bin_s;
    logic [SLICE-1:0]   sl_d_s;
    logic [SLICE:1]     sl_borrow_s;

    // Slice addressing derived from the running index
    always_comb begin
        idx_d    = idx_q + IDX_W'(1);
        base_s   = BASE_W'(idx_q) * BASE_W'(SLICE);
        last_s   = (idx_q == IDX_W'(NSLICE - 1));
        sl_a_s   = a_q[base_s +: SLICE];
        sl_b_s   = b_q[base_s +: SLICE];
        sl_bin_s = borrow_q[base_s];
    end

    sub_slice #(
        .SLICE (SLICE)
    ) u_sub_slice (
        .a_i      (sl_a_s),
        .b_i      (sl_b_s),
        .bin_i    (sl_bin_s),
        .d_o      (sl_d_s),
        .borrow_o (sl_borrow_s)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= '0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= {{WIDTH{1'b0}}, bin};
                        diff_q     <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    diff_q[base_s +: SLICE]                   <= sl_d_s;
                    borrow_q[base_s + BASE_W'(1) +: SLICE]    <= sl_borrow_s;
                    idx_q                                     <= idx_d;
                    if (last_s) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Release only; a concurrent in_valid is taken next cycle in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    idx_q       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign res       = {borrow_q, diff_q};

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: SLICE=1 and SLICE=4 instances checked
// against an arithmetic reference model with random operands and backpressure.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           in_valid_v [2];
    logic           in_ready_v [2];
    logic           out_valid_v[2];
    logic           out_ready_v[2];
    logic           bin_v      [2];
    logic [W-1:0]   a_v        [2];
    logic [W-1:0]   b_v        [2];
    logic [W-1:0]   diff_v     [2];
    logic [W:0]     borrow_v   [2];
    logic [2*W:0]   res_v      [2];

    int tests = 0;
    int fails = 0;
    int or_mode[2];
    int pend[2];
    logic           adder_flag[2];
    logic [W-1:0]   adder_x[2];

    typedef struct packed {
        logic [W-1:0] diff;
        logic [W:0]   borrow;
    } exp_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // borrow[i] is set exactly when the low i bits of a are below those of b plus bin
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int d;
        int m;
        d = int'(a) - int'(b) - int'(bin);
        e.diff = d[W-1:0];
        e.borrow[0] = bin;
        for (int i = 1; i <= W; i++) begin
            m = 1 << i;
            e.borrow[i] = ((int'(a) % m) < ((int'(b) % m) + int'(bin)));
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SL = (g == 0) ? 1 : 4;
        localparam int NS = W / SL;

        serial_subtractor #(.WIDTH(W), .SLICE(SL)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .bin       (bin_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .diff      (diff_v[g]),
            .borrow    (borrow_v[g]),
            .res       (res_v[g])
        );

        exp_t          q[$];
        int            lat;
        logic          busy = 1'b0;
        logic          seen = 1'b0;
        logic          held = 1'b0;
        logic [2*W:0]  held_res;

        always @(negedge clk) begin
            exp_t e;
            if (reset) begin
                q.delete();
                pend[g] = 0;
                busy = 1'b0;
                seen = 1'b0;
                held = 1'b0;
            end else begin
                if (busy) begin
                    lat++;
                    if (in_ready_v[g]) check($sformatf("in_ready_busy%0d", g), 64'(in_ready_v[g]), 64'd0);
                end
                if (out_valid_v[g]) begin
                    if (busy && !seen) begin
                        seen = 1'b1;
                        check($sformatf("latency%0d", g), 64'(lat), 64'(NS + 1));
                    end
                    if (held) check($sformatf("res_hold%0d", g), 64'(res_v[g]), 64'(held_res));
                    held = 1'b1;
                    held_res = res_v[g];
                    if (out_ready_v[g]) begin
                        if (q.size() == 0) begin
                            check($sformatf("unexpected_out%0d", g), 64'(res_v[g]), 64'h1_dead_beef);
                        end else begin
                            e = q.pop_front();
                            pend[g] = pend[g] - 1;
                            check($sformatf("diff%0d", g), 64'(diff_v[g]), 64'(e.diff));
                            check($sformatf("borrow%0d", g), 64'(borrow_v[g]), 64'(e.borrow));
                            check($sformatf("res%0d", g), 64'(res_v[g]), 64'({e.borrow, e.diff}));
                        end
                        held = 1'b0;
                        busy = 1'b0;
                    end
                end else begin
                    held = 1'b0;
                end
                if (in_valid_v[g] && in_ready_v[g]) begin
                    e = model(a_v[g], b_v[g], bin_v[g]);
                    if (adder_flag[g]) e.diff = adder_x[g];
                    q.push_back(e);
                    pend[g] = pend[g] + 1;
                    busy = 1'b1;
                    seen = 1'b0;
                    lat = 0;
                end
            end
        end
    end

    // out_ready driver: 0 random, 1 held high, 2 held low
    initial begin
        out_ready_v[0] = 1'b1;
        out_ready_v[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (or_mode[k] == 0) out_ready_v[k] = 1'($urandom_range(0, 1));
                else out_ready_v[k] = (or_mode[k] == 1);
            end
        end
    end

    task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic add, input logic [W-1:0] x);
        bit ok;
        ok = 1'b0;
        a_v[k] = a;
        b_v[k] = b;
        bin_v[k] = bi;
        adder_flag[k] = add;
        adder_x[k] = x;
        in_valid_v[k] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready_v[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        a_v[k] = 8'($urandom);
        b_v[k] = 8'($urandom);
        bin_v[k] = 1'($urandom);
    endtask

    task automatic wait_valid(input int k);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid_v[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_random(input int k, input int n);
        logic [W-1:0] x;
        logic [W-1:0] y;
        or_mode[k] = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 4) == 0) begin
                x = 8'($urandom);
                y = 8'($urandom);
                issue(k, x + y, y, 1'b0, 1'b1, x);
            end else begin
                issue(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 8'h00);
            end
        end
    endtask

    logic [W-1:0] dir_a  [4] = '{8'h05, 8'h00, 8'h80, 8'h80};
    logic [W-1:0] dir_b  [4] = '{8'h03, 8'h01, 8'h80, 8'h7F};
    logic         dir_bi [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
    logic [W-1:0] dir_d  [4] = '{8'h02, 8'hFF, 8'hFF, 8'h01};
    logic [W:0]   dir_br [4] = '{9'h004, 9'h1FE, 9'h1FF, 9'h0FE};

    initial begin
        logic [2*W:0] cap;
        bit saw;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid_v[k] = 1'b0;
            a_v[k] = '0;
            b_v[k] = '0;
            bin_v[k] = 1'b0;
            or_mode[k] = 1;
            pend[k] = 0;
            adder_flag[k] = 1'b0;
            adder_x[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready", 64'(in_ready_v[k]), 64'd1);
            check("rst_out_valid", 64'(out_valid_v[k]), 64'd0);
            check("rst_res", 64'(res_v[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            issue(0, dir_a[i], dir_b[i], dir_bi[i], 1'b0, 8'h00);
            wait_valid(0);
            check($sformatf("dir%0d_diff", i), 64'(diff_v[0]), 64'(dir_d[i]));
            check($sformatf("dir%0d_borrow", i), 64'(borrow_v[0]), 64'(dir_br[i]));
            check($sformatf("dir%0d_res", i), 64'(res_v[0]), 64'({dir_br[i], dir_d[i]}));
        end

        or_mode[0] = 2;
        @(posedge clk);
        #1;
        issue(0, 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h00);
        wait_valid(0);
        cap = res_v[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_v[0] = 8'($urandom);
            b_v[0] = 8'($urandom);
            in_valid_v[0] = 1'($urandom);
            @(negedge clk);
            check("bp_valid", 64'(out_valid_v[0]), 64'd1);
            check("bp_res", 64'(res_v[0]), 64'(cap));
        end
        in_valid_v[0] = 1'b0;
        or_mode[0] = 1;
        repeat (3) @(posedge clk);

        #1;
        issue(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("abort_diff", 64'(diff_v[0]), 64'd0);
        check("abort_borrow", 64'(borrow_v[0]), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid_v[0]) saw = 1'b1;
        end
        check("abort_no_output", 64'(saw), 64'd0);

        @(posedge clk);
        #1;
        fork
            run_random(0, 1000);
            run_random(1, 300);
        join
        or_mode[0] = 1;
        or_mode[1] = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (pend[0] == 0 && pend[1] == 0) break;
        end
        check("drain0", 64'(pend[0]), 64'd0);
        check("drain1", 64'(pend[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached with %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
